// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch buffer:
// NOP word, default sizes, control-state encoding and opcode/funct fields.
package imem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;

    localparam logic [DATA_W_DEF-1:0] NOP = '0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OPR_ADD = 6'h20;
    localparam logic [5:0] OPR_SUB = 6'h22;

endpackage

// File: rtl/imem_fetch_buffer_if.sv
// Fetch request/response, flush, program-load and count signals of the fetch buffer.
// master = fetch unit / loader side, slave = the buffer itself.
interface imem_fetch_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_fault;
    logic              resp_ready;
    logic              flush;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [31:0]       fetch_count;

    modport master (
        output req_valid, req_addr, resp_ready, flush, prog_we, prog_addr, prog_data,
        input  req_ready, resp_valid, resp_data, resp_fault, fetch_count
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, prog_we, prog_addr, prog_data,
        output req_ready, resp_valid, resp_data, resp_fault, fetch_count
    );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x DATA_W, one synchronous read-first read port,
// one write port. Deliberately unreset so a program survives reset.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports in one block: the read samples the pre-write word.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/imem_fetch_buffer.sv
// One-entry fetch buffer in front of the instruction array; optional bounds
// checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
//   state    | meaning
//   ST_EMPTY | no response held, resp_valid=0
//   ST_FULL  | response held in the array read register, resp_valid=1
module imem_fetch_buffer
    import imem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    imem_fetch_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    fetch_state_e      state_q, state_d;
    logic              accept, fire, fault_q;
    logic              req_oob, prog_oob, wr_en;
    logic [DATA_W-1:0] rd_word;
    logic [31:0]       count_q;

`ifdef IMEM_BOUNDS_CHECK_EN
    generate
        if (ADDR_W > IDX_W) begin : g_oob
            assign req_oob  = |bus.req_addr[ADDR_W-1:IDX_W];
            assign prog_oob = |bus.prog_addr[ADDR_W-1:IDX_W];
        end else begin : g_no_oob
            assign req_oob  = 1'b0;
            assign prog_oob = 1'b0;
        end
    endgenerate
`else
    assign req_oob  = 1'b0;
    assign prog_oob = 1'b0;
    // Upper address bits simply alias onto the array.
    generate
        if (ADDR_W > IDX_W) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^{bus.req_addr[ADDR_W-1:IDX_W], bus.prog_addr[ADDR_W-1:IDX_W]};
        end
    endgenerate
`endif

    assign bus.req_ready = (state_q == ST_EMPTY || bus.resp_ready) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign fire          = (state_q == ST_FULL) && bus.resp_ready && !bus.flush;
    assign wr_en         = bus.prog_we && !prog_oob;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                fault_q <= req_oob;
            end
            if (fire) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && bus.resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // The read register only loads on accept, so a held response is immune to writes.
    assign bus.resp_valid  = (state_q == ST_FULL);
    assign bus.resp_data   = (state_q == ST_FULL && !fault_q) ? rd_word : DATA_W'(NOP);
    assign bus.resp_fault  = (state_q == ST_FULL) && fault_q;
    assign bus.fetch_count = count_q;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock   (clock),
        .rd_en   (accept),
        .rd_idx  (bus.req_addr[IDX_W-1:0]),
        .rd_data (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (bus.prog_addr[IDX_W-1:0]),
        .wr_data (bus.prog_data)
    );
endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed bench for imem_fetch_buffer with a queue-free reference model
// checked every cycle plus literal expectations; honours IMEM_BOUNDS_CHECK_EN.
module tb_imem_fetch_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    imem_fetch_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    imem_fetch_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the buffer must be holding, from the behavioural rules.
    logic [31:0] m_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_fault;
    logic [31:0] m_count;

    function automatic logic is_oob(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_fault = 1'b0;
            m_count = '0;
        end else begin
            logic rdy;
            rdy = (!m_valid || bus.resp_ready) && !bus.flush;
            if (m_valid && bus.resp_ready && !bus.flush) m_count = m_count + 1;
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.req_valid && rdy) begin
                m_valid = 1'b1;
                m_fault = is_oob(bus.req_addr);
                m_data  = m_fault ? 32'h0 : m_mem[bus.req_addr % DEPTH];
            end else if (bus.resp_ready) begin
                m_valid = 1'b0;
            end
            if (bus.prog_we && !is_oob(bus.prog_addr)) m_mem[bus.prog_addr % DEPTH] = bus.prog_data;
        end
    end

    always @(negedge clk) begin
        chk("cyc_resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        chk("cyc_req_ready", 32'(bus.req_ready),
            32'((!m_valid || bus.resp_ready) && !bus.flush));
        chk("cyc_fetch_count", bus.fetch_count, m_count);
        if (!rst_n || m_valid) begin
            chk("cyc_resp_data", bus.resp_data, m_valid ? m_data : 32'h0);
            chk("cyc_resp_fault", 32'(bus.resp_fault), 32'(m_valid && m_fault));
        end
    end

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        tick();
        bus.prog_we = 1'b0;
    endtask

    initial begin
        bus.req_valid = 0; bus.req_addr = 0; bus.resp_ready = 0; bus.flush = 0;
        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        tick(); tick();
        chk("rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_data", bus.resp_data, 32'h0);
        chk("rst_count", bus.fetch_count, 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) prog(i, 32'hA500_0000 | i);
        prog(0, 32'h0042_1020);
        prog(1, 32'h0022_1020);
        prog(2, 32'h1001_FFFD);

        // three back-to-back fetches
        bus.resp_ready = 1; bus.req_valid = 1; bus.req_addr = 0;
        tick(); chk("b2b_w0", bus.resp_data, 32'h0042_1020);
        bus.req_addr = 1;
        tick(); chk("b2b_w1", bus.resp_data, 32'h0022_1020);
        bus.req_addr = 2;
        tick(); chk("b2b_w2", bus.resp_data, 32'h1001_FFFD);
        bus.req_valid = 0;
        tick(); chk("b2b_count", bus.fetch_count, 32'd3);
        chk("b2b_empty", 32'(bus.resp_valid), 32'h0);

        // stall with resp_ready low
        bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 1;
        tick();
        bus.req_addr = 2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
            chk("stall_data", bus.resp_data, 32'h0022_1020);
            chk("stall_count", bus.fetch_count, 32'd3);
        end
        bus.resp_ready = 1; bus.req_valid = 0;
        tick(); chk("stall_release_count", bus.fetch_count, 32'd4);

        // same-cycle write and read of idx 5
        bus.prog_we = 1; bus.prog_addr = 5; bus.prog_data = 32'hDEAD_BEEF;
        bus.req_valid = 1; bus.req_addr = 5;
        tick(); bus.prog_we = 0;
        chk("rfirst_old", bus.resp_data, 32'hA500_0005);
        tick(); chk("rfirst_new", bus.resp_data, 32'hDEAD_BEEF);
        bus.req_valid = 0;
        tick(); chk("rfirst_count", bus.fetch_count, 32'd6);

        // held response unaffected by a write to its index
        bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 0;
        tick(); bus.req_valid = 0;
        prog(0, 32'h1111_1111);
        chk("hold_vs_write", bus.resp_data, 32'h0042_1020);

        // flush while held, with a competing request and resp_ready high
        bus.flush = 1; bus.resp_ready = 1; bus.req_valid = 1; bus.req_addr = 2;
        #1 chk("flush_req_ready", 32'(bus.req_ready), 32'h0);
        tick(); bus.flush = 0; bus.req_valid = 0;
        chk("flush_valid", 32'(bus.resp_valid), 32'h0);
        chk("flush_count", bus.fetch_count, 32'd6);
        prog(0, 32'h0042_1020);

        // out-of-range fetch
        bus.req_valid = 1; bus.req_addr = DEPTH + 2;
        tick(); bus.req_valid = 0;
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("oob_data", bus.resp_data, 32'h0);
        chk("oob_fault", 32'(bus.resp_fault), 32'h1);
`else
        chk("oob_data", bus.resp_data, 32'h1001_FFFD);
        chk("oob_fault", 32'(bus.resp_fault), 32'h0);
`endif
        tick(); chk("oob_count", bus.fetch_count, 32'd7);

        // reset while FULL
        bus.resp_ready = 0; bus.req_valid = 1; bus.req_addr = 1;
        tick(); bus.req_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("mid_rst_data", bus.resp_data, 32'h0);
        chk("mid_rst_count", bus.fetch_count, 32'h0);
        tick(); rst_n = 1;
        bus.resp_ready = 1; bus.req_valid = 1; bus.req_addr = 0;
        tick(); bus.req_valid = 0;
        chk("post_rst_word", bus.resp_data, 32'h0042_1020);
        tick(); chk("post_rst_count", bus.fetch_count, 32'd1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_fetch_buffer.md
IMEM_FETCH_BUFFER -- requirements
Module: imem_fetch_buffer

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 32: request and program address width; addresses are word indices.
REQ-003 Parameter DEPTH, default 256: number of instruction words stored; power of two, at least 2.
REQ-004 clock  input  1: single clock; all state updates on posedge clock.
REQ-005 reset_n  input  1: reset is asynchronous and active-low.
REQ-006 req_valid  input  1: fetch request present.
REQ-007 req_addr  input  ADDR_W: fetch word index.
REQ-008 req_ready  output  1: request accepted this cycle when req_valid is also high.
REQ-009 resp_valid  output  1: resp_data holds a fetched word.
REQ-010 resp_data  output  DATA_W: fetched instruction word.
REQ-011 resp_fault  output  1: response came from an out-of-range address.
REQ-012 resp_ready  input  1: consumer takes the response this cycle.
REQ-013 flush  input  1: discard any pending response (branch redirect).
REQ-014 prog_we  input  1: program-load write strobe.
REQ-015 prog_addr  input  ADDR_W, prog_data  input  DATA_W: program-load word index and data.
REQ-016 fetch_count  output  32: count of completed responses.

Function
REQ-017 Control FSM shall have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-018 req_ready shall be (state==EMPTY || resp_ready) && !flush, combinationally.
REQ-019 On an accepted request at edge N, resp_valid shall be 1 and resp_data=mem[req_addr] after edge N (latency 1).
REQ-020 In FULL with resp_ready=1 and no new accept, the FSM shall go to EMPTY; with a new accept it shall stay FULL with the new word (back-to-back, one word per cycle).
REQ-021 In FULL with resp_ready=0, resp_data and resp_fault shall stay stable until the handshake completes.
REQ-022 flush=1 shall force EMPTY at the next edge regardless of resp_ready; no request is accepted in a flush cycle.
REQ-023 prog_we=1 shall write prog_data to mem[prog_addr] at the edge; writes are allowed in any FSM state.
REQ-024 A write and an accepted read to the same index in one cycle shall return the old word (read-first).
REQ-025 A write shall not change a response already held in FULL.
REQ-026 fetch_count shall increment by 1 on each cycle with resp_valid && resp_ready && !flush; it wraps from 0xFFFFFFFF to 0.
REQ-027 Storage index shall be the low log2(DEPTH) bits of the address.

Reset
REQ-028 While reset_n=0: FSM EMPTY, resp_valid=0, resp_data=0, resp_fault=0, fetch_count=0; req_ready follows REQ-018.
REQ-029 Storage contents shall not be reset and shall be kept across reset.
REQ-030 Reset asserted mid-handshake shall drop the held response; no count increment.

Configuration
REQ-031 Macro IMEM_BOUNDS_CHECK_EN defined: a request with req_addr >= DEPTH returns resp_data=NOP (all zeros) and resp_fault=1, and prog_we to prog_addr >= DEPTH is ignored.
REQ-032 Macro IMEM_BOUNDS_CHECK_EN undefined: addresses alias per REQ-027 and resp_fault is tied to 0.

Structure
REQ-033 Package imem_pkg shall hold the NOP constant, default DATA_W/DEPTH, the FSM state typedef, and the opcode/funct constants (OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OPR_ADD, OPR_SUB).
REQ-034 Storage shall be the sub-module imem_array: DEPTH x DATA_W, one synchronous read-first read port and one write port, no reset.

Verification
REQ-035 Program idx 0..2 = 0x00421020, 0x00221020, 0x1001FFFD; fetch 0,1,2 with resp_ready=1 -> same words on three consecutive cycles, fetch_count=3.
REQ-036 Fetch idx 1, hold resp_ready=0 for 4 cycles -> req_ready=0, resp_data stable at 0x00221020, count unchanged; release -> count +1.
REQ-037 Write 0xDEADBEEF to idx 5 while fetching idx 5 in the same cycle -> old word returned; next fetch of idx 5 returns 0xDEADBEEF.
REQ-038 Hold a response in FULL, pulse flush -> resp_valid=0 next cycle, count unchanged, req_ready=0 during the flush cycle.
REQ-039 Fetch idx DEPTH+2 -> with IMEM_BOUNDS_CHECK_EN: data 0, fault 1; without: data = word at idx 2, fault 0.
REQ-040 Assert reset_n=0 while FULL -> outputs and count are 0 at once; after release, fetch idx 0 returns the preloaded word.
